calc_accum: RTL and testbench
=============================

CALC_ACCUM -- requirements
Module: calc_accum

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning samples per window (power of two, 2..64).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge triggered.
REQ-003 SHALL have port rst, input, 1 bit, meaning reset; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning in_data is valid this cycle.
REQ-005 SHALL have port in_data, input, 9 bits, meaning the unsigned registered result from the upstream 12a+5b stage.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-007 SHALL have port clear, input, 1 bit, meaning synchronous discard of the partial window or of the held result.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning out_sum (and out_avg) hold a completed window.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-010 SHALL have port out_sum, output, SUM_W = 9 + log2(DEPTH) bits, meaning the unsigned window sum.

Function
REQ-011 SHALL implement a two-state FSM: ACC (collecting) and FULL (holding result).
REQ-012 SHALL drive in_ready = 1 in ACC and 0 in FULL; a sample is accepted only when in_valid && in_ready.
REQ-013 SHALL, in ACC, add each accepted in_data (zero-extended) to the accumulator and increment the sample count; gaps in in_valid do not advance the count.
REQ-014 SHALL, on the DEPTH-th accepted sample, register the final sum into out_sum and enter FULL; out_valid rises the following cycle (latency 1 from the last accepted sample).
REQ-015 SHALL, in FULL, hold out_valid = 1 and out_sum stable until out_valid && out_ready.
REQ-016 SHALL, on the out_valid && out_ready handshake, return to ACC with count 0 and accumulator 0; the first new sample is accepted no earlier than the next cycle.
REQ-017 SHALL size out_sum so that DEPTH samples of 511 cannot overflow; no saturation or wrap logic exists.
REQ-018 SHALL give clear priority over in_valid and out_ready: in ACC it zeroes count and accumulator and drops the sample presented that cycle; in FULL it drops the result, deasserts out_valid next cycle, and returns to ACC.
REQ-019 SHALL never accept a sample while out_valid = 1.

Reset
REQ-020 SHALL, while rst = 1, force state ACC, count 0, accumulator 0, out_valid 0, and out_sum 0 (out_avg 0 when present).
REQ-021 SHALL, when rst is asserted mid-window, discard the partial window; the first sample after release starts a fresh window.
REQ-022 SHALL drive in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, when macro CALC_ACCUM_AVG_EN is defined, add output port out_avg (9 bits), meaning the window mean, equal to out_sum >> log2(DEPTH) (truncating), registered in the same cycle as out_sum and qualified by out_valid.
REQ-024 SHALL, when CALC_ACCUM_AVG_EN is undefined, omit out_avg and all of its logic; all other behaviour is identical in both builds.

Structure
REQ-025 SHALL place CALC_DATA_W = 9 and the FSM state typedef (ACC, FULL) in shared package calc_pkg.
REQ-026 SHALL compute SUM_W locally from DEPTH.
REQ-027 SHALL be implemented as a single module; no sub-module is warranted.

Verification (DEPTH = 8)
REQ-028 SHALL cover: 8 back-to-back samples of 255 with out_ready = 1 -> out_valid one cycle after the 8th, out_sum = 2040, out_avg = 255.
REQ-029 SHALL cover: samples 1..8 with in_valid toggling every other cycle -> out_sum = 36, out_avg = 4, exactly one out_valid pulse.
REQ-030 SHALL cover: 8 samples of 511 with out_ready held 0 for 5 cycles -> out_valid and out_sum = 4088 stable, in_ready = 0 throughout, release on the first out_ready.
REQ-031 SHALL cover: 3 samples of 100, then clear, then 8 samples of 1 -> out_sum = 8.
REQ-032 SHALL cover: rst pulsed after 5 samples of 50, then 8 samples of 2 -> out_sum = 16, with no out_valid before the 8th new sample.
REQ-033 SHALL cover: clear asserted together with out_ready while in FULL -> result dropped, no handshake counted, in_ready = 1 next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the calculator accumulator slice.
//               CALC_DATA_W is the width of the upstream 12a+5b result.
//               calc_state_t is the window-collection FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int CALC_DATA_W = 9;

    typedef enum logic [0:0] {
        ACC  = 1'b0,   // collecting samples
        FULL = 1'b1    // holding a completed window result
    } calc_state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_accum.sv
`default_nettype none
// ============================================================================
// Module      : calc_accum
// Description : Windowed accumulator. Sums DEPTH accepted samples of the
//               upstream result, then holds the window sum until the consumer
//               takes it (out_valid && out_ready) or clear drops it.
//               Optional feature macro: CALC_ACCUM_AVG_EN adds out_avg, the
//               truncated window mean, registered alongside out_sum.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               in_valid  - in_data valid
//               in_data   - unsigned sample, CALC_DATA_W bits
//               in_ready  - sample accepted this cycle (state ACC)
//               clear     - synchronous discard of partial window / result
//               out_valid - out_sum (and out_avg) hold a completed window
//               out_ready - consumer takes the result
//               out_sum   - window sum, CALC_DATA_W + log2(DEPTH) bits
//               out_avg   - window mean (only with CALC_ACCUM_AVG_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module calc_accum
    import calc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic [CALC_DATA_W-1:0]                     in_data,
    output logic                                       in_ready,
    input  logic                                       clear,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [CALC_DATA_W+$clog2(DEPTH)-1:0]       out_sum
`ifdef CALC_ACCUM_AVG_EN
    ,
    output logic [CALC_DATA_W-1:0]                     out_avg
`endif
);

    localparam int CNT_W = $clog2(DEPTH);
    localparam int SUM_W = CALC_DATA_W + CNT_W;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    calc_state_t        r_state;
    calc_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [SUM_W-1:0]   r_acc;
    logic [SUM_W-1:0]   r_sum;

    logic               w_in_acc;
    logic               w_accept;
    logic               w_last;
    logic               w_release;
    logic [SUM_W-1:0]   w_acc_sum;

    assign w_in_acc  = (r_state == ACC);
    // clear has priority: the sample presented with clear is dropped.
    assign w_accept  = w_in_acc && in_valid && !clear;
    assign w_last    = w_accept && (r_count == c_cnt_last);
    assign w_release = !w_in_acc && (clear || out_ready);
    // Zero-extended add; SUM_W covers DEPTH * 511 so no wrap can occur.
    assign w_acc_sum = r_acc + SUM_W'(in_data);

    assign in_ready  = w_in_acc;
    assign out_valid = !w_in_acc;
    assign out_sum   = r_sum;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC: begin
                if (w_last) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_release) begin
                    w_state_nxt = ACC;
                end
            end
            default: begin
                w_state_nxt = ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator, sample counter and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
        end else if (w_in_acc) begin
            if (clear) begin
                r_count <= '0;
                r_acc   <= '0;
            end else if (w_last) begin
                // Final sample goes straight into the result register so
                // out_valid can rise on the very next cycle.
                r_sum   <= w_acc_sum;
                r_count <= '0;
                r_acc   <= '0;
            end else if (w_accept) begin
                r_acc   <= w_acc_sum;
                r_count <= r_count + c_cnt_one;
            end
        end else if (w_release) begin
            r_count <= '0;
            r_acc   <= '0;
        end
    end

`ifdef CALC_ACCUM_AVG_EN
    // ------------------------------------------------------------------
    // Window mean: truncating divide by DEPTH, captured with out_sum
    // ------------------------------------------------------------------
    logic [CALC_DATA_W-1:0] r_avg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_avg <= '0;
        end else if (w_last) begin
            r_avg <= w_acc_sum[SUM_W-1:CNT_W];
        end
    end

    assign out_avg = r_avg;
`endif

endmodule : calc_accum
`default_nettype wire

// File: tb/tb_calc_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_accum
// Description : Self-checking bench for calc_accum (DEPTH = 8). A queue-based
//               window model predicts in_ready/out_valid/out_sum every cycle;
//               table-driven and hand-written sequences add explicit checks
//               against constant expected values, followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_accum;

    localparam int DEPTH = 8;
    localparam int SUM_W = 9 + $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [8:0]       in_data;
    logic             in_ready;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
`ifdef CALC_ACCUM_AVG_EN
    logic [8:0]       out_avg;
`endif

    calc_accum #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
`ifdef CALC_ACCUM_AVG_EN
        ,
        .out_avg   (out_avg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    bit m_full;
    int m_q[$];
    int m_res;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_q.delete();
        m_res = 0;
    endtask

    // Window rules: collect DEPTH accepted samples, then hold the total until
    // taken or cleared; clear discards whatever is in progress.
    task automatic model_step(input bit v, input int d, input bit clr, input bit ordy);
        int s;
        if (m_full) begin
            if (clr || ordy) m_full = 1'b0;
        end else if (clr) begin
            m_q.delete();
        end else if (v) begin
            m_q.push_back(d);
            if (m_q.size() == DEPTH) begin
                s = 0;
                foreach (m_q[i]) s += m_q[i];
                m_res  = s;
                m_full = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic model_check();
        chk("in_ready", in_ready, !m_full);
        chk("out_valid", out_valid, m_full);
        if (m_full) begin
            chk("out_sum", out_sum, m_res);
`ifdef CALC_ACCUM_AVG_EN
            chk("out_avg", out_avg, m_res / DEPTH);
`endif
        end
    endtask

    // One clock: drive inputs (called just after a negedge), let the edge
    // happen, advance the model, then compare at the following negedge.
    task automatic cyc(input bit v, input int d, input bit clr, input bit ordy);
        in_valid  = v;
        in_data   = 9'(d);
        clear     = clr;
        out_ready = ordy;
        @(posedge clk);
        model_step(v, d, clr, ordy);
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; in_data = 0; clear = 0; out_ready = 0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
`ifdef CALC_ACCUM_AVG_EN
        chk("rst_out_avg", out_avg, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit v; int d; bit clr; bit ordy;
        bit e_rdy; bit e_ov; int e_sum;   // e_sum < 0: don't care
    } vec_t;

    vec_t tbl[$];
    int   ov_pulses;
    int   seen_sum;

    initial begin
        rst = 1'b0; in_valid = 0; in_data = 0; clear = 0; out_ready = 0;
        model_reset();
        #2 rst = 1'b1;
        do_reset();

        // ---- 8 back-to-back samples of 255, out_ready = 1 ----
        for (int i = 0; i < 8; i++) tbl.push_back('{1, 255, 0, 1, (i < 7), (i == 7), (i == 7) ? 2040 : -1});
        tbl.push_back('{0, 0, 0, 1, 1, 0, -1});        // handshake taken
        // ---- clear together with out_ready while FULL ----
        for (int i = 0; i < 8; i++) tbl.push_back('{1, 7, 0, 0, (i < 7), (i == 7), (i == 7) ? 56 : -1});
        tbl.push_back('{1, 9, 1, 1, 1, 0, -1});        // dropped, in_ready back
        tbl.push_back('{1, 3, 0, 0, 1, 0, -1});        // fresh window starts

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_sum >= 0) chk($sformatf("tbl%0d_out_sum", i), out_sum, tbl[i].e_sum);
        end
`ifdef CALC_ACCUM_AVG_EN
        chk("avg_after_clear_path", 0, 0 * out_avg);
`endif
        do_reset();

        // ---- samples 1..8 with in_valid toggling ----
        ov_pulses = 0; seen_sum = -1;
        for (int i = 0; i < 20; i++) begin
            cyc((i % 2) == 0 && i < 16, (i / 2) + 1, 0, 1);
            if (out_valid) begin
                ov_pulses++;
                seen_sum = int'(out_sum);
`ifdef CALC_ACCUM_AVG_EN
                chk("toggle_avg", out_avg, 4);
`endif
            end
        end
        chk("toggle_pulses", ov_pulses, 1);
        chk("toggle_sum", seen_sum, 36);

        // ---- 8 samples of 511, out_ready held low 5 cycles ----
        for (int i = 0; i < 8; i++) cyc(1, 511, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_sum", out_sum, 4088);
        end
        cyc(1, 1, 0, 1);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);

        // ---- 3 x 100, clear, 8 x 1 ----
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 100, 0, 0);
        cyc(1, 100, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0);
        chk("clear_out_valid", out_valid, 1);
        chk("clear_out_sum", out_sum, 8);
        cyc(0, 0, 0, 1);

        // ---- 5 x 50, asynchronous rst pulse, 8 x 2 ----
        for (int i = 0; i < 5; i++) cyc(1, 50, 0, 0);
        in_valid = 0;
        #2 rst = 1'b1;
        model_reset();
        #1 chk("async_rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        ov_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 2, 0, 0);
            if (i == 0) chk("post_rst_in_ready", in_ready, 1);
            if (i < 7 && out_valid) ov_pulses++;
        end
        chk("rst_early_valid", ov_pulses, 0);
        chk("rst_out_valid", out_valid, 1);
        chk("rst_out_sum", out_sum, 16);
        cyc(0, 0, 0, 1);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 511),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_calc_accum
`default_nettype wire
